// File: rtl/id_ex_operand_stage_if.sv
// rtl/id_ex_operand_stage_if.sv - ID/EX operand stage signal bundle (ID fields, hazard controls, forwarding buses, EX outputs)
interface id_ex_operand_stage_if #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5,
  parameter int OP_W   = 4
);
  logic              id_valid;
  logic [RA_W-1:0]   id_rs;
  logic [RA_W-1:0]   id_rt;
  logic [DATA_W-1:0] id_rs_val;
  logic [DATA_W-1:0] id_rt_val;
  logic              id_uses_rt;
  logic [DATA_W-1:0] id_imm;
  logic              id_use_imm;
  logic [OP_W-1:0]   id_alu_op;
  logic [4:0]        id_sa;
  logic [RA_W-1:0]   id_rd;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              stall;
  logic              flush;
  logic              exmem_reg_write;
  logic [RA_W-1:0]   exmem_rd;
  logic [DATA_W-1:0] exmem_res;
  logic              memwb_reg_write;
  logic [RA_W-1:0]   memwb_rd;
  logic [DATA_W-1:0] memwb_data;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_a;
  logic [DATA_W-1:0] ex_b;
  logic [DATA_W-1:0] ex_store_data;
  logic [OP_W-1:0]   ex_op;
  logic [4:0]        ex_sa;
  logic [RA_W-1:0]   ex_rd;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              load_use;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_val, id_rt_val, id_uses_rt, id_imm, id_use_imm,
           id_alu_op, id_sa, id_rd, id_reg_write, id_mem_read, stall, flush,
           exmem_reg_write, exmem_rd, exmem_res, memwb_reg_write, memwb_rd, memwb_data,
    input  ex_valid, ex_a, ex_b, ex_store_data, ex_op, ex_sa, ex_rd, ex_reg_write,
           ex_mem_read, load_use
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_val, id_rt_val, id_uses_rt, id_imm, id_use_imm,
           id_alu_op, id_sa, id_rd, id_reg_write, id_mem_read, stall, flush,
           exmem_reg_write, exmem_rd, exmem_res, memwb_reg_write, memwb_rd, memwb_data,
    output ex_valid, ex_a, ex_b, ex_store_data, ex_op, ex_sa, ex_rd, ex_reg_write,
           ex_mem_read, load_use
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and load-use bubble
module id_ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5,
  parameter int OP_W   = 4,
  parameter bit FWD_EN = 1'b1
) (
  input logic clk,
  input logic rst_n,
  id_ex_operand_stage_if.slave bus
);
  logic              valid_q;
  logic [RA_W-1:0]   rs_q;
  logic [RA_W-1:0]   rt_q;
  logic [DATA_W-1:0] rs_val_q;
  logic [DATA_W-1:0] rt_val_q;
  logic [DATA_W-1:0] imm_q;
  logic              use_imm_q;
  logic [OP_W-1:0]   op_q;
  logic [4:0]        sa_q;
  logic [RA_W-1:0]   rd_q;
  logic              reg_write_q;
  logic              mem_read_q;

  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;
  logic              load_use;

  // EX/MEM is younger than MEM/WB, so it takes priority; $0 always reads zero
  always_comb begin
    fwd_rs = rs_val_q;
    if (rs_q == '0) begin
      fwd_rs = '0;
    end else if (FWD_EN && valid_q) begin
      if (bus.exmem_reg_write && bus.exmem_rd == rs_q)
        fwd_rs = bus.exmem_res;
      else if (bus.memwb_reg_write && bus.memwb_rd == rs_q)
        fwd_rs = bus.memwb_data;
    end
  end

  always_comb begin
    fwd_rt = rt_val_q;
    if (rt_q == '0) begin
      fwd_rt = '0;
    end else if (FWD_EN && valid_q) begin
      if (bus.exmem_reg_write && bus.exmem_rd == rt_q)
        fwd_rt = bus.exmem_res;
      else if (bus.memwb_reg_write && bus.memwb_rd == rt_q)
        fwd_rt = bus.memwb_data;
    end
  end

  always_comb begin
    load_use = valid_q && mem_read_q && (rd_q != '0) && bus.id_valid && !bus.flush &&
               ((bus.id_rs == rd_q) || (bus.id_uses_rt && bus.id_rt == rd_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      rs_q        <= '0;
      rt_q        <= '0;
      rs_val_q    <= '0;
      rt_val_q    <= '0;
      imm_q       <= '0;
      use_imm_q   <= 1'b0;
      op_q        <= '0;
      sa_q        <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else if (bus.flush || (!bus.stall && load_use)) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else if (bus.stall) begin
      // capture forwarded values so they survive once the producer leaves MEM/WB
      rs_val_q <= fwd_rs;
      rt_val_q <= fwd_rt;
    end else begin
      valid_q     <= bus.id_valid;
      rs_q        <= bus.id_rs;
      rt_q        <= bus.id_rt;
      rs_val_q    <= bus.id_rs_val;
      rt_val_q    <= bus.id_rt_val;
      imm_q       <= bus.id_imm;
      use_imm_q   <= bus.id_use_imm;
      op_q        <= bus.id_alu_op;
      sa_q        <= bus.id_sa;
      rd_q        <= bus.id_rd;
      reg_write_q <= bus.id_reg_write;
      mem_read_q  <= bus.id_mem_read;
    end
  end

  assign bus.ex_valid      = valid_q;
  assign bus.ex_a          = fwd_rs;
  assign bus.ex_b          = use_imm_q ? imm_q : fwd_rt;
  assign bus.ex_store_data = fwd_rt;
  assign bus.ex_op         = op_q;
  assign bus.ex_sa         = sa_q;
  assign bus.ex_rd         = rd_q;
  assign bus.ex_reg_write  = reg_write_q & valid_q;
  assign bus.ex_mem_read   = mem_read_q & valid_q;
  assign bus.load_use      = load_use;
endmodule
